// File: rtl/fib_pkg.sv
// fib_pkg: shared widths and enums for the FIB tree walker
package fib_pkg;
    localparam int WORD_SIZE_DEF    = 16;
    localparam int POINTER_SIZE_DEF = 16;
    typedef enum logic [1:0] {IDLE, FETCH, COMPARE, RESP} walk_state_t;
    typedef enum logic [1:0] {CMP_EQ, CMP_LT, CMP_GT} cmp_result_t;
endpackage

// File: rtl/fib_key_compare.sv
// fib_key_compare: unsigned three-way compare of search key against node word
module fib_key_compare import fib_pkg::*; #(
    parameter int W = WORD_SIZE_DEF
) (
    input  logic [W-1:0] key,
    input  logic [W-1:0] word,
    output cmp_result_t  result
);
    assign result = (key == word) ? CMP_EQ : (key < word) ? CMP_LT : CMP_GT;
endmodule

// File: rtl/fib_tree_walker.sv
// fib_tree_walker: BST lookup over FIB node storage; FIB_WALK_STATS_EN adds saturating stat counters
module fib_tree_walker import fib_pkg::*; #(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int POINTER_SIZE = POINTER_SIZE_DEF,
    parameter int MAX_DEPTH = 16,
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    req_valid_in,
    output logic                    req_ready_out,
    input  logic [WORD_SIZE-1:0]    key_in,
    input  logic [POINTER_SIZE-1:0] root_pointer_in,
    output logic                    node_rd_en_out,
    output logic [POINTER_SIZE-1:0] node_addr_out,
    input  logic [WORD_SIZE-1:0]    node_data_word_in,
    input  logic [POINTER_SIZE-1:0] node_left_pointer_in,
    input  logic [POINTER_SIZE-1:0] node_right_pointer_in,
    input  logic                    node_valid_bit_in,
    input  logic                    node_left_valid_bit_in,
    input  logic                    node_right_valid_bit_in,
    output logic                    resp_valid_out,
    input  logic                    resp_ready_in,
    output logic                    resp_hit_out,
    output logic                    resp_abort_out,
    output logic [POINTER_SIZE-1:0] resp_pointer_out,
    output logic [DEPTH_W-1:0]      resp_depth_out
`ifdef FIB_WALK_STATS_EN
    ,
    output logic [31:0]             stat_lookups_out,
    output logic [31:0]             stat_hits_out,
    output logic [31:0]             stat_aborts_out
`endif
);
    walk_state_t              state;
    cmp_result_t              cmp;
    logic [WORD_SIZE-1:0]     key;
    logic [POINTER_SIZE-1:0]  cur_ptr;
    logic [DEPTH_W-1:0]       depth;
    logic                     is_hit;
    logic                     descend;
    logic [POINTER_SIZE-1:0]  next_ptr;

    fib_key_compare #(.W(WORD_SIZE)) u_cmp (
        .key    (key),
        .word   (node_data_word_in),
        .result (cmp)
    );

    assign req_ready_out = !rst_in && state == IDLE;
    assign is_hit = node_valid_bit_in && cmp == CMP_EQ;
    assign descend = node_valid_bit_in && (cmp == CMP_LT ? node_left_valid_bit_in :
                                           cmp == CMP_GT ? node_right_valid_bit_in : 1'b0);
    assign next_ptr = cmp == CMP_LT ? node_left_pointer_in : node_right_pointer_in;

    // Strobe and address are registered on entry to FETCH so the read is sampled on FETCH's exit edge
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= IDLE;
            key              <= '0;
            cur_ptr          <= '0;
            depth            <= '0;
            node_rd_en_out   <= 1'b0;
            node_addr_out    <= '0;
            resp_valid_out   <= 1'b0;
            resp_hit_out     <= 1'b0;
            resp_abort_out   <= 1'b0;
            resp_pointer_out <= '0;
            resp_depth_out   <= '0;
`ifdef FIB_WALK_STATS_EN
            stat_lookups_out <= '0;
            stat_hits_out    <= '0;
            stat_aborts_out  <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid_in) begin
                    key            <= key_in;
                    cur_ptr        <= root_pointer_in;
                    depth          <= '0;
                    node_rd_en_out <= 1'b1;
                    node_addr_out  <= root_pointer_in;
                    state          <= FETCH;
                end
                FETCH: begin
                    node_rd_en_out <= 1'b0;
                    depth          <= depth + DEPTH_W'(1);
                    state          <= COMPARE;
                end
                COMPARE: if (descend && depth != DEPTH_W'(MAX_DEPTH)) begin
                    cur_ptr        <= next_ptr;
                    node_rd_en_out <= 1'b1;
                    node_addr_out  <= next_ptr;
                    state          <= FETCH;
                end else begin
                    resp_valid_out   <= 1'b1;
                    resp_hit_out     <= is_hit;
                    resp_abort_out   <= descend;
                    resp_pointer_out <= cur_ptr;
                    resp_depth_out   <= depth;
                    state            <= RESP;
                end
                RESP: if (resp_ready_in) begin
                    resp_valid_out <= 1'b0;
                    state          <= IDLE;
`ifdef FIB_WALK_STATS_EN
                    if (~&stat_lookups_out) stat_lookups_out <= stat_lookups_out + 32'd1;
                    if (resp_hit_out && ~&stat_hits_out) stat_hits_out <= stat_hits_out + 32'd1;
                    if (resp_abort_out && ~&stat_aborts_out) stat_aborts_out <= stat_aborts_out + 32'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
